// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state enum and the tap-parity feedback
// used by both the PRBS generator and the checker.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 32;

  typedef enum logic {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic lfsr_feedback(
    input logic [LFSR_MAX_W-1:0] win,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return ^(win & taps);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Serial PRBS checker: self-seeds from the stream, then free-runs and compares.
// Define LFSR_CHK_AUTO_RESYNC_EN for windowed loss-of-lock detection.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int           N               = 8,
  parameter logic [N-1:0] TAPS            = 'b00000011,
  parameter bit           VARIABLE_CONFIG = 1'b0,
  parameter int           CNT_W           = 16
`ifdef LFSR_CHK_AUTO_RESYNC_EN
  ,
  parameter int           WINDOW          = 64,
  parameter int           THRESH          = 8
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             load_config_i,
  input  logic [N-1:0]     taps_i,
  input  logic             data_i,
  input  logic             valid_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] bit_count_o
);

  localparam int SW = $clog2(N + 1);

  chk_state_t    state_q, state_d;
  logic [N-1:0]  win_q, win_d;
  logic [N-1:0]  taps_q;
  logic [SW-1:0] seed_q, seed_d;
  logic          err_q;
  logic          load, pred, cmp, miss, lol;

  assign load = VARIABLE_CONFIG && load_config_i;
  assign pred = lfsr_feedback(LFSR_MAX_W'(win_q), LFSR_MAX_W'(taps_q));
  assign cmp  = valid_i && !load && (state_q == LOCKED);
  assign miss = cmp && (data_i != pred);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    seed_d  = seed_q;
    if (load) begin
      state_d = SEED;
      seed_d  = '0;
    end else if (valid_i) begin
      unique case (state_q)
        SEED: begin
          win_d = {data_i, win_q[N-1:1]};
          if (seed_q != SW'(N)) seed_d = seed_q + 1'b1;
          if ((seed_d == SW'(N)) && (win_d != '0)) state_d = LOCKED;
        end
        LOCKED: begin
          // predicted bit, not received: keeps one flip to one error
          win_d = {pred, win_q[N-1:1]};
          if (lol) begin
            state_d = SEED;
            seed_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SEED;
      win_q   <= '0;
      seed_q  <= '0;
      taps_q  <= TAPS;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      seed_q  <= seed_d;
      err_q   <= miss;
      if (load) taps_q <= taps_i;
    end
  end

  assign locked_o = (state_q == LOCKED);
  assign err_o    = err_q;

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .inc_i   (miss),
    .count_o (err_count_o)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .inc_i   (cmp),
    .count_o (bit_count_o)
  );

`ifdef LFSR_CHK_AUTO_RESYNC_EN
  localparam int WW = $clog2(WINDOW + 1);

  logic [WW-1:0] wbits, werrs;
  logic          wrap, wclr;

  assign lol  = miss && (werrs == WW'(THRESH - 1));
  assign wrap = cmp && (wbits == WW'(WINDOW - 1));
  assign wclr = clear_i || lol || wrap;

  sat_counter #(.W(WW)) u_win_bits (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (wclr),
    .inc_i   (cmp),
    .count_o (wbits)
  );

  sat_counter #(.W(WW)) u_win_errs (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (wclr),
    .inc_i   (miss),
    .count_o (werrs)
  );
`else
  assign lol = 1'b0;
`endif

endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

Serial PRBS checker that sits directly downstream of the LFSR generator and consumes its `data_o`/`valid_o` bitstream. It seeds a local copy of the generator from the first N received bits, then predicts every following bit and compares it with the received one. It reports lock status, per-bit error pulses, and saturating error and bit counters. It is used in loopback and link BER tests.

## Interface
- `N`, 8: LFSR width; must match the upstream generator.
- `TAPS`, 8'b00000011: feedback taps used when `VARIABLE_CONFIG`=0; also the reset value of the internal taps register.
- `VARIABLE_CONFIG`, 0: 1 = taps are loaded at runtime from `taps_i`.
- `CNT_W`, 16: width of both counters.
- `WINDOW`, 64: loss-of-lock observation window, in compared bits (macro only).
- `THRESH`, 8: error count within `WINDOW` that declares loss of lock (macro only).

Ports:
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `clear_i`  in  1  synchronous clear of counters and loss-of-lock window.
- `load_config_i`  in  1  latch `taps_i` and reseed (only when `VARIABLE_CONFIG`=1; ignored otherwise).
- `taps_i`  in  N  runtime taps.
- `data_i`  in  1  received bit.
- `valid_i`  in  1  `data_i` is valid this cycle.
- `locked_o`  out  1  checker is in LOCKED.
- `err_o`  out  1  one-cycle pulse: the compared bit mismatched.
- `err_count_o`  out  CNT_W  saturating count of mismatches.
- `bit_count_o`  out  CNT_W  saturating count of compared bits.

## Operation
- Window register `win[N-1:0]`: a new bit enters at the MSB and the register shifts right, so `win[i]` is the bit received i positions after the oldest bit. Predicted bit = XOR over i of (`win[i]` & `taps[i]`).
- States:
  - SEED:
    - Each valid bit is shifted in and `seed_cnt` increments, saturating at N.
    - When `seed_cnt` reaches N and `win` ≠ 0, go to LOCKED.
    - An all-zero `win` keeps the checker in SEED (sliding window), so it never locks on the all-zero state.
  - LOCKED:
    - Each valid bit is compared with the prediction.
    - `win` shifts in the *predicted* bit, making the local generator free-running, so one flipped bit produces exactly one error.
    - `bit_count` increments on every compare; `err_count` increments on every mismatch.
- Counters saturate at all-ones and never wrap.
- `clear_i`:
  - Zeroes both counters and the window counters.
  - Does not change state or `win`.
  - When it coincides with a mismatch, the count becomes 0 but `err_o` still pulses.
- `load_config_i` (`VARIABLE_CONFIG`=1):
  - Latches `taps_i` and enters SEED with `seed_cnt`=0. Counters are unaffected.
  - If it coincides with `valid_i`, the load wins and the bit is discarded.
- `valid_i`=0: nothing advances and `err_o`=0.
- Reset values:
  - SEED, `win`=0, `seed_cnt`=0, taps=`TAPS`.
  - `locked_o`=0, `err_o`=0, `err_count_o`=0, `bit_count_o`=0.

## Timing
- All outputs are registered.
- `err_o` and the counter updates appear 1 cycle after the valid bit is sampled.
- `locked_o` rises 1 cycle after the Nth qualifying seed bit is sampled.
- `locked_o` falls 1 cycle after a `load_config_i` or loss-of-lock event.
- `reset_i` mid-operation clears everything immediately (asynchronously), independent of the clock.
- Full throughput: one bit per cycle with back-to-back `valid_i`.

## Configuration
- `LFSR_CHK_AUTO_RESYNC_EN` defined:
  - A window counter counts compared bits and a window error counter counts mismatches.
  - When the window error counter reaches `THRESH` before `WINDOW` bits have been compared, go to SEED with `seed_cnt`=0 and clear both window counters.
  - Both window counters restart every `WINDOW` compared bits.
- Undefined: LOCKED is left only via reset or `load_config_i`, and `WINDOW`/`THRESH` are unused.

## Structure
- Shared package `lfsr_pkg`:
  - state enum `chk_state_t` {SEED, LOCKED}
  - parity/feedback function `lfsr_feedback(win, taps)`, reused by the generator.
- Sub-module `sat_counter` (width parameter, increment, clear, saturate), instantiated for the error, bit and window counters.

## Test plan
- Generator with start 8'h01, taps 8'b00000011, 1000 bits back-to-back:
  - `locked_o`=1 on the cycle after bit 8
  - `err_count_o`=0
  - `bit_count_o`=992
- Same stream with bit 100 inverted: exactly one `err_o` pulse, `err_count_o`=1, `locked_o` stays 1.
- 32 zero bits with `valid_i`=1: `locked_o` stays 0, both counters stay 0.
- `CNT_W`=4 with 20 injected errors: `err_count_o` saturates at 15.
- `VARIABLE_CONFIG`=1, `load_config_i` with taps 8'b10001110 while locked:
  - `locked_o`=0 next cycle
  - relocks 8 valid bits after the upstream stream restarts with the new taps
  - counters keep their values
- Macro defined (`WINDOW`=64, `THRESH`=8), random bits after lock: `locked_o` drops within 64 bits, relocks 8 bits after a clean stream resumes. Assert `reset_i` mid-lock: all outputs are 0 immediately.
